// File: rtl/spram_req_ctrl_if.sv
// Request/response channel and spram port bundle for spram_req_ctrl.
// slave  : controller side (accepts requests, drives the spram port).
// master : client side (issues requests, models the spram).
interface spram_req_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_me;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_me, mem_wen, mem_wdata, busy
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_me, mem_wen, mem_wdata, busy
  );
endinterface

// File: rtl/spram_req_ctrl.sv
// spram_req_ctrl: single-outstanding request controller in front of a
// single-port RAM. One response is returned per accepted request.
// Optional feature macro: SPRAM_WR_VERIFY_EN (read-back check after writes).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a request (req_ready high)
// S_ACCESS| one-cycle spram access with the captured request
// S_WAIT  | read in flight, counting down RD_LAT
// S_VRD   | read-back access to the just-written address (verify only)
// S_VWAIT | read-back in flight, counting down RD_LAT (verify only)
// S_RSP   | response presented, held until rsp_ready
module spram_req_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  spram_req_ctrl_if.slave bus
);

  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
`ifdef SPRAM_WR_VERIFY_EN
    S_VRD    = 3'd4,
    S_VWAIT  = 3'd5,
`endif
    S_RSP    = 3'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req_ready;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [CNT_W-1:0]  r_cnt;

  logic w_accept;
  logic w_mem_me;
  logic w_mem_wen;
  logic w_rsp_valid;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cap_rd;
`ifdef SPRAM_WR_VERIFY_EN
  logic r_rsp_err;
  logic w_cap_vfy;
`endif

  // State register; req_ready is registered so it stays low through reset
  // and only rises once the FSM is genuinely back in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mem_me    = 1'b0;
    w_mem_wen   = 1'b0;
    w_rsp_valid = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cap_rd    = 1'b0;
`ifdef SPRAM_WR_VERIFY_EN
    w_cap_vfy   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_mem_me  = 1'b1;
        w_mem_wen = r_wr;
        if (r_wr) begin
`ifdef SPRAM_WR_VERIFY_EN
          w_state_nxt = S_VRD;
`else
          w_state_nxt = S_RSP;
`endif
        end else begin
          w_cnt_load  = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_dec = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_cap_rd    = 1'b1;
          w_state_nxt = S_RSP;
        end
      end
`ifdef SPRAM_WR_VERIFY_EN
      S_VRD: begin
        w_mem_me    = 1'b1;
        w_cnt_load  = 1'b1;
        w_state_nxt = S_VWAIT;
      end
      S_VWAIT: begin
        w_cnt_dec = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_cap_vfy   = 1'b1;
          w_state_nxt = S_RSP;
        end
      end
`endif
      S_RSP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture, latency down-counter and response data registers.
  // Response regs are cleared on accept so a plain write answers with 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_cnt       <= '0;
`ifdef SPRAM_WR_VERIFY_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_wr        <= bus.req_wr;
        r_addr      <= bus.req_addr;
        r_wdata     <= bus.req_wdata;
        r_rsp_rdata <= '0;
`ifdef SPRAM_WR_VERIFY_EN
        r_rsp_err   <= 1'b0;
`endif
      end
      if (w_cnt_load) begin
        r_cnt <= CNT_W'(RD_LAT);
      end else if (w_cnt_dec && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_cap_rd) begin
        r_rsp_rdata <= bus.mem_rdata;
      end
`ifdef SPRAM_WR_VERIFY_EN
      if (w_cap_vfy) begin
        r_rsp_rdata <= bus.mem_rdata;
        r_rsp_err   <= (bus.mem_rdata != r_wdata);
      end
`endif
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
`ifdef SPRAM_WR_VERIFY_EN
  assign bus.rsp_err   = r_rsp_err;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign bus.mem_addr  = r_addr;
  assign bus.mem_me    = w_mem_me;
  assign bus.mem_wen   = w_mem_wen;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Testbench for spram_req_ctrl with a behavioural 256x32 spram, RD_LAT=1.
// Also builds with SPRAM_WR_VERIFY_EN defined (adds the read-back checks).
module tb_spram_req_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;
`ifdef SPRAM_WR_VERIFY_EN
  localparam bit VFY    = 1'b1;
  localparam int WR_LAT = 3 + RD_LAT;
  localparam int WR_ME  = 2;
`else
  localparam bit VFY    = 1'b0;
  localparam int WR_LAT = 2;
  localparam int WR_ME  = 1;
`endif
  localparam int RDLAT_EXP = 2 + RD_LAT;

  logic clk;
  logic reset;
  logic fill;
  logic [31:0] flip_mask;
  logic [31:0] mem [256];
  logic [31:0] rd_q;
  int me_cnt;
  int wen_bad;
  int n_checks;
  int n_errors;

  spram_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spram_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // spram model: synchronous write, one-cycle registered read
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | i;
    end else if (bus.mem_me && bus.mem_wen) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_me && !bus.mem_wen) rd_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rd_q ^ flip_mask;

  always @(posedge clk) begin
    if (bus.mem_me) me_cnt <= me_cnt + 1;
    if (bus.mem_wen && !bus.mem_me) wen_bad <= wen_bad + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int lat,
                        output int mep, output bit to);
    int w;
    int me0;
    to = 1'b0; rd = '0; err = 1'b0; lat = 0; mep = 0;
    @(negedge clk);
    w = 0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.req_ready) begin to = 1'b1; return; end
    me0 = me_cnt;
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!bus.rsp_valid) begin to = 1'b1; return; end
    rd = bus.rsp_rdata;
    err = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    mep = me_cnt - me0;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d;
    v.exp_rd = wr ? (VFY ? d : 32'h0) : e;
    return v;
  endfunction

  vec_t vecs [11];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          mep;
    bit          to;
    int          bad;
    int          w;

    vecs[0]  = mk(1'b1, 8'h3C, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(1'b0, 8'h3C, 32'h0,        32'hDEADBEEF);
    vecs[2]  = mk(1'b1, 8'h00, 32'h00000000, 32'h0);
    vecs[3]  = mk(1'b1, 8'hFF, 32'hFFFFFFFF, 32'h0);
    vecs[4]  = mk(1'b0, 8'h00, 32'h0,        32'h00000000);
    vecs[5]  = mk(1'b0, 8'hFF, 32'h0,        32'hFFFFFFFF);
    vecs[6]  = mk(1'b1, 8'h00, 32'hFFFFFFFF, 32'h0);
    vecs[7]  = mk(1'b1, 8'hFF, 32'h00000000, 32'h0);
    vecs[8]  = mk(1'b0, 8'h00, 32'h0,        32'hFFFFFFFF);
    vecs[9]  = mk(1'b0, 8'hFF, 32'h0,        32'h00000000);
    vecs[10] = mk(1'b1, 8'h10, 32'hA5A55A5A, 32'h0);

    n_checks = 0; n_errors = 0; me_cnt = 0; wen_bad = 0;
    flip_mask = '0; rd_q = '0; fill = 1'b1;
    reset = 1'b0;
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h55;
    bus.req_wdata = '0; bus.rsp_ready = 1'b0;

    // reset held with a pending request
    repeat (4) @(negedge clk);
    fill = 1'b0;
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_mem_me", bus.mem_me, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 8'h00);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1'b1);
    chk("post_rst_me_count", me_cnt, 0);

    // table-driven requests
    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, lat, mep, to);
      chk($sformatf("v%0d_timeout", i), to, 1'b0);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), err, 1'b0);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].wr ? WR_LAT : RDLAT_EXP);
      chk($sformatf("v%0d_me_pulses", i), mep, vecs[i].wr ? WR_ME : 1);
      @(negedge clk);
      chk($sformatf("v%0d_ready_back", i), bus.req_ready, 1'b1);
    end

    // back-pressure on a read of 0xFF
    do_req(1'b1, 8'hFF, 32'h13579BDF, rd, err, lat, mep, to);
    chk("bp_setup_timeout", to, 1'b0);
    @(negedge clk);
    mep = me_cnt;
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.req_addr = 8'h3C;
    bus.req_wr = 1'b1;
    w = 0;
    while (!bus.rsp_valid && w < 20) begin @(negedge clk); w++; end
    chk("bp_rsp_seen", bus.rsp_valid, 1'b1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_rdata_c%0d", c), bus.rsp_rdata, 32'h13579BDF);
      chk($sformatf("bp_valid_c%0d", c), bus.rsp_valid, 1'b1);
      if (bus.req_ready || bus.mem_me) bad++;
      @(negedge clk);
    end
    chk("bp_ready_me_low", bad, 0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_single_rsp", bus.rsp_valid, 1'b0);
    chk("bp_me_pulses", me_cnt - mep, 1);
    chk("bp_mem_3c_untouched", mem[8'h3C], 32'hDEADBEEF);

    // reset while the read sits in WAIT
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h10;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) bad++;
    end
    chk("mid_rst_no_rsp", bad, 0);
    do_req(1'b0, 8'h10, 32'h0, rd, err, lat, mep, to);
    chk("mid_rst_rd_timeout", to, 1'b0);
    chk("mid_rst_rd_data", rd, 32'hA5A55A5A);
    chk("mid_rst_rd_latency", lat, RDLAT_EXP);

`ifdef SPRAM_WR_VERIFY_EN
    do_req(1'b1, 8'h20, 32'h12345678, rd, err, lat, mep, to);
    chk("vfy_ok_err", err, 1'b0);
    chk("vfy_ok_rdata", rd, 32'h12345678);
    chk("vfy_ok_latency", lat, 3 + RD_LAT);
    flip_mask = 32'h0000_0001;
    do_req(1'b1, 8'h20, 32'h12345678, rd, err, lat, mep, to);
    flip_mask = '0;
    chk("vfy_bad_err", err, 1'b1);
    chk("vfy_bad_rdata", rd, 32'h12345679);
`endif

    chk("wen_without_me", wen_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
